apb_master: RTL
===============

# apb_master

Single-channel APB3 requester that converts the CPU core's one-shot data-bus requests into APB SETUP/ACCESS transfers. It decodes the address to one of four peripheral selects (RAM, GPO, GPI, GPIO), waits for the selected slave's PREADY, and returns read data with a one-cycle completion pulse. It sits directly upstream of the APB RAM and the other APB peripherals. A wait-state timeout and an unmapped-address check return an error rather than hanging the core.

## Interface
- TIMEOUT, 16: maximum ACCESS-phase cycles to wait for PREADY before aborting with error (must be ≥2).
- BASE_HI, 20'h10000: value of addr[31:16]/addr[31:12] base. Slave n is selected when addr[31:12] == BASE_HI + n, n = 0..3.

Ports:
- PCLK  in  1  clock; all logic rising-edge.
- PRESET  in  1  asynchronous, active-low reset.
- transfer  in  1  one-cycle request pulse from the core; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; captured with transfer.
- addr  in  32  byte address; captured with transfer.
- wdata  in  32  write data; captured with transfer.
- rdata  out  32  read data; valid only while ready = 1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready: timeout or unmapped address.
- PADDR  out  32  APB address (the captured addr, unmodified).
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PSEL  out  4  one-hot slave select. Bit 0 is RAM, 1 is GPO, 2 is GPI, 3 is GPIO.
- PRDATA0..PRDATA3  in  32 each  per-slave read data.
- PREADY0..PREADY3  in  1 each  per-slave ready.

## Operation
- FSM states:
  - IDLE: PSEL = 0, PENABLE = 0.
    - transfer = 1 with a mapped address: capture addr, wdata and write into PADDR, PWDATA and PWRITE; latch the select index; go to SETUP.
    - transfer = 1 with an unmapped address: no APB cycle; go to DONE with err = 1.
  - SETUP: PSEL[idx] = 1, PENABLE = 0; unconditionally go to ACCESS.
  - ACCESS: PSEL[idx] = 1, PENABLE = 1; increment the wait counter every cycle.
    - PREADY[idx] = 1: register PRDATA[idx] into rdata (reads only; writes leave rdata = 0); go to DONE with err = 0.
    - Otherwise, counter == TIMEOUT−1: go to DONE with err = 1 and rdata = 0.
  - DONE: ready = 1 for exactly this cycle; PSEL = 0, PENABLE = 0; go to IDLE. transfer is ignored here.
- PREADY and PRDATA of unselected slaves are ignored.
- PADDR, PWDATA and PWRITE hold stable from SETUP through DONE and until the next capture.
- The wait counter is cleared on entry to SETUP. It is ceil(log2(TIMEOUT))+1 bits wide and does not wrap.
- transfer while not in IDLE is dropped. The core must not pulse transfer again until it has seen ready.

## Timing
- Reset (PRESET = 0, asynchronous) forces:
  - state to IDLE;
  - PSEL, PENABLE, PWRITE, ready and err to 0;
  - PADDR, PWDATA and rdata to 0;
  - the counter to 0.
- Reset mid-transfer aborts without a ready pulse. Release is synchronous to the next PCLK edge.
- Cycle numbering: transfer is high in cycle 0 (IDLE), SETUP is cycle 1, ACCESS is entered in cycle 2.
- Zero-wait slave (PREADY = 1 in the first ACCESS cycle): DONE / ready in cycle 3.
- Registered-PREADY slave (the RAM asserts PREADY one cycle after sampling PSEL & PENABLE): PREADY is seen in cycle 3, so DONE / ready is in cycle 4.
- Back-to-back: the earliest next transfer is accepted in the cycle after DONE, i.e. 4 cycles per transfer minimum.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, so ready with err = 1 is in cycle 2 + TIMEOUT.
- Unmapped address: ready with err = 1 in cycle 1; PSEL never asserts.
- PREADY arriving in the same cycle the counter hits TIMEOUT−1: PREADY wins (normal completion, err = 0).

## Test plan
- Write to RAM: addr 0x1000_0010, wdata 0xA5A5_1234, registered-PREADY RAM model.
  - Required: PSEL = 4'b0001 in cycles 1–3, PENABLE in cycles 2–3, PWRITE = 1, PADDR = 0x1000_0010.
  - Required: ready in cycle 4 with err = 0.
- Read back from addr 0x1000_0010.
  - Required: rdata = 0xA5A5_1234 with ready in cycle 4, err = 0; PWRITE = 0 throughout.
- Read from GPI (addr 0x1000_2000), zero-wait slave returning 0x0000_00FF, with PRDATA0 = 0xFFFF_FFFF driven on an unselected port.
  - Required: PSEL = 4'b0100; rdata = 0x0000_00FF in cycle 3.
- Timeout: slave 3 never asserts PREADY, TIMEOUT = 16.
  - Required: ACCESS lasts 16 cycles; ready and err = 1 in cycle 18; rdata = 0.
- Unmapped address 0x2000_0000.
  - Required: ready and err = 1 in cycle 1; PSEL stays 0.
  - A second transfer pulsed during DONE is ignored.
- Reset pulse (PRESET low) during ACCESS.
  - Required: all outputs 0 immediately; no ready pulse.
  - A subsequent write completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// APB3 bus between the single requester and its four peripheral slaves.
// Per-slave read data / ready are kept as separate signals so each slave
// drives only its own return path.
interface apb_master_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic        PREADY0;
    logic        PREADY1;
    logic        PREADY2;
    logic        PREADY3;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        input  PREADY0, PREADY1, PREADY2, PREADY3
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
        output PREADY0, PREADY1, PREADY2, PREADY3
    );
endinterface

// File: rtl/apb_master.sv
// Single-channel APB3 requester: turns one-shot core requests into
// SETUP/ACCESS transfers to one of four 4 KB slave windows, with a
// wait-state timeout and an unmapped-address error path.
module apb_master #(
    parameter int          TIMEOUT = 16,
    parameter logic [19:0] BASE_HI = 20'h10000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    apb_master_if.master apb
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   paddr, pwdata;
    logic          pwrite;

    // Window offset from the base; wrapping subtraction makes anything below
    // the base land far above 3, so one compare covers both sides.
    logic [19:0] off;
    logic        mapped;
    assign off    = addr[31:12] - BASE_HI;
    assign mapped = (off < 20'd4);

    logic [3:0]  pready_v;
    logic [31:0] prdata_v [4];
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        timeout;

    // Gather per-slave returns so only the latched select is ever looked at.
    always_comb begin
        pready_v    = {apb.PREADY3, apb.PREADY2, apb.PREADY1, apb.PREADY0};
        prdata_v[0] = apb.PRDATA0;
        prdata_v[1] = apb.PRDATA1;
        prdata_v[2] = apb.PRDATA2;
        prdata_v[3] = apb.PRDATA3;
        sel_ready   = pready_v[idx];
        sel_rdata   = prdata_v[idx];
    end

    assign timeout = (cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state: PREADY is tested before the timeout so a same-cycle
    // arrival completes normally.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (transfer) state_nxt = mapped ? SETUP : DONE;
            SETUP:  state_nxt = ACCESS;
            ACCESS: if (sel_ready || timeout) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counter and completion status.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            paddr  <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (transfer) begin
                    if (mapped) begin
                        paddr  <= addr;
                        pwdata <= wdata;
                        pwrite <= write;
                        idx    <= off[1:0];
                        cnt    <= '0;
                    end else begin
                        err    <= 1'b1;
                        rdata  <= '0;
                    end
                end
                ACCESS: begin
                    // Saturate rather than wrap; the timeout exit keeps it in range anyway.
                    if (cnt != {CW{1'b1}}) cnt <= cnt + CW'(1);
                    if (sel_ready) begin
                        rdata <= pwrite ? 32'd0 : sel_rdata;
                        err   <= 1'b0;
                    end else if (timeout) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                DONE:    err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ready       = (state == DONE);
    assign apb.PSEL    = (state == SETUP || state == ACCESS) ? (4'b0001 << idx) : 4'b0000;
    assign apb.PENABLE = (state == ACCESS);
    assign apb.PADDR   = paddr;
    assign apb.PWDATA  = pwdata;
    assign apb.PWRITE  = pwrite;
endmodule
